// File: rtl/bin_ram_reader_pkg.sv
// bin_ram_reader_pkg: shared address width, reader FSM states and packer bit placement
package bin_ram_reader_pkg;
  localparam int BIN_ADDR_W = 11;
  typedef enum logic [1:0] {ST_IDLE, ST_READ, ST_DRAIN} state_t;
  function automatic logic [5:0] bit_pos(input logic [5:0] cnt, input int w, input bit msb_first);
    return msb_first ? 6'(w - 1) - cnt : cnt;
  endfunction
endpackage

// File: rtl/bin_bit_packer.sv
// bin_bit_packer: serial bits into OUT_W-bit words on a valid/ready stream, zero-padded short last word
module bin_bit_packer
  import bin_ram_reader_pkg::*;
#(
  parameter int OUT_W     = 8,
  parameter int MSB_FIRST = 0
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             i_bit_valid,
  input  logic             i_bit,
  input  logic             i_bit_last,
  output logic [5:0]       o_cnt,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [OUT_W-1:0] o_data,
  output logic             o_last
);
  logic [OUT_W-1:0] r_acc, r_data, w_word;
  logic [5:0] r_cnt;
  logic r_hold, r_hold_last, r_valid, r_last;
  logic w_end, w_end_last, w_move;
  assign o_cnt   = r_cnt;
  assign o_valid = r_valid;
  assign o_data  = r_data;
  assign o_last  = r_last;
  always_comb begin
    w_word     = r_acc | ((i_bit_valid & i_bit) ? OUT_W'(1) << bit_pos(r_cnt, OUT_W, MSB_FIRST != 0) : '0);
    w_end      = r_hold | (i_bit_valid & (r_cnt == 6'(OUT_W - 1) | i_bit_last));
    w_end_last = r_hold ? r_hold_last : i_bit_last;
    w_move     = w_end & (~r_valid | i_ready);
  end
  // a completed word that cannot move yet is held in the accumulator (r_hold)
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_acc       <= '0;
      r_cnt       <= '0;
      r_hold      <= 1'b0;
      r_hold_last <= 1'b0;
      r_valid     <= 1'b0;
      r_data      <= '0;
      r_last      <= 1'b0;
    end else if (w_move) begin
      r_data      <= w_word;
      r_last      <= w_end_last;
      r_valid     <= 1'b1;
      r_acc       <= '0;
      r_cnt       <= '0;
      r_hold      <= 1'b0;
    end else begin
      if (r_valid & i_ready) r_valid <= 1'b0;
      r_acc       <= w_word;
      r_cnt       <= r_cnt + 6'(i_bit_valid);
      r_hold      <= w_end;
      r_hold_last <= w_end_last;
    end
  end
endmodule

// File: rtl/bin_ram_reader.sv
// bin_ram_reader: reads len bits of a 1-bit line RAM from base_addr and streams them packed into words
module bin_ram_reader
  import bin_ram_reader_pkg::*;
#(
  parameter int ADDR_WIDTH = BIN_ADDR_W,
  parameter int OUT_W      = 8,
  parameter int MSB_FIRST  = 0
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH:0]   len,
  output logic                  busy,
  output logic                  done,
  output logic                  ram_en,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  input  logic                  ram_rd_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [OUT_W-1:0]      out_data,
  output logic                  out_last
);
  state_t r_state, w_next;
  logic [ADDR_WIDTH-1:0] r_addr, r_ram_addr;
  logic [ADDR_WIDTH:0] r_left;
  logic r_ram_en, r_ram_last, r_rd_pend, r_rd_last, r_done;
  logic w_go, w_issue, w_final, w_pk_valid, w_pk_last;
  logic [5:0] w_pk_cnt;
  logic [6:0] w_occ;
  logic [OUT_W-1:0] w_pk_data;
  assign busy      = r_state != ST_IDLE;
  assign done      = r_done;
  assign ram_en    = r_ram_en;
  assign ram_addr  = r_ram_addr;
  assign out_valid = w_pk_valid;
  assign out_data  = w_pk_data;
  assign out_last  = w_pk_last;
  // packer holds at most one accumulating word plus the output word; in-flight reads count against that
  always_comb begin
    w_go    = r_state == ST_IDLE && start && len != '0;
    w_final = w_pk_valid & out_ready & w_pk_last;
    w_occ   = ((w_pk_valid & ~out_ready) ? 7'(OUT_W) : 7'd0) + 7'(w_pk_cnt) + 7'(r_rd_pend) + 7'(r_ram_en) + 7'd1;
    w_issue = r_state == ST_READ && r_left != '0 && w_occ <= 7'(2 * OUT_W);
    w_next  = r_state;
    if (w_go) w_next = ST_READ;
    if (r_state == ST_READ && r_left == '0) w_next = ST_DRAIN;
    if (r_state == ST_DRAIN && w_final) w_next = ST_IDLE;
  end
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_state <= ST_IDLE;
    else r_state <= w_next;
  end
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_addr     <= '0;
      r_ram_addr <= '0;
      r_left     <= '0;
      r_ram_en   <= 1'b0;
      r_ram_last <= 1'b0;
      r_rd_pend  <= 1'b0;
      r_rd_last  <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_ram_en  <= w_go | w_issue;
      r_rd_pend <= r_ram_en;
      r_rd_last <= r_ram_en & r_ram_last;
      r_done    <= (r_state == ST_IDLE && start && len == '0) | (r_state == ST_DRAIN && w_final);
      if (w_go) begin
        r_ram_addr <= base_addr;
        r_addr     <= base_addr + ADDR_WIDTH'(1);
        r_left     <= len - (ADDR_WIDTH + 1)'(1);
        r_ram_last <= len == (ADDR_WIDTH + 1)'(1);
      end else if (w_issue) begin
        r_ram_addr <= r_addr;
        r_addr     <= r_addr + ADDR_WIDTH'(1);
        r_left     <= r_left - (ADDR_WIDTH + 1)'(1);
        r_ram_last <= r_left == (ADDR_WIDTH + 1)'(1);
      end
    end
  end
  bin_bit_packer #(.OUT_W(OUT_W), .MSB_FIRST(MSB_FIRST)) u_packer (
    .clk        (clk),
    .rstn       (rstn),
    .i_bit_valid(r_rd_pend),
    .i_bit      (ram_rd_data),
    .i_bit_last (r_rd_last),
    .o_cnt      (w_pk_cnt),
    .o_valid    (w_pk_valid),
    .i_ready    (out_ready),
    .o_data     (w_pk_data),
    .o_last     (w_pk_last)
  );
endmodule

// File: tb/tb_bin_ram_reader.sv
// tb_bin_ram_reader: random line reads checked against a word-packing reference built from RAM contents
module tb_bin_ram_reader;
  localparam int AW = 11;
  localparam int W  = 8;
  localparam int N  = 2 ** AW;
  logic clk = 1'b0, rstn = 1'b0, start = 1'b0, out_ready = 1'b1, ram_rd_data = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [AW:0] len = '0;
  logic busy, done, ram_en, out_valid, out_last;
  logic [AW-1:0] ram_addr;
  logic [W-1:0] out_data;
  bit ram [N];
  int vectors = 0, errors = 0;
  logic [W-1:0] exp_q[$];
  int exp_addr_q[$];
  int cyc, beats, en_cnt, t_valid, t_done, t_last_beat, t_last_en;
  bit mon = 1'b0, rand_rdy = 1'b0, hold_v, hold_l, busy1, busy_done;
  logic [W-1:0] hold_d;

  bin_ram_reader #(.ADDR_WIDTH(AW), .OUT_W(W), .MSB_FIRST(0)) dut (
    .clk(clk), .rstn(rstn), .start(start), .base_addr(base_addr), .len(len),
    .busy(busy), .done(done), .ram_en(ram_en), .ram_addr(ram_addr), .ram_rd_data(ram_rd_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last)
  );

  always #5 clk = ~clk;
  always @(posedge clk) if (ram_en) ram_rd_data <= ram[ram_addr];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  initial forever begin
    @(posedge clk);
    #1 out_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  always @(negedge clk) if (mon) begin
    cyc++;
    if (cyc == 1) busy1 = busy;
    if (ram_en) begin
      en_cnt++;
      t_last_en = cyc;
      if (exp_addr_q.size() != 0) check("ram_addr", 32'(ram_addr), 32'(exp_addr_q.pop_front()));
      else check("extra_ram_en", 1, 0);
    end
    if (out_valid && t_valid < 0) t_valid = cyc;
    if (hold_v) begin
      check("stall_valid", 32'(out_valid), 1);
      check("stall_data", 32'(out_data), 32'(hold_d));
      check("stall_last", 32'(out_last), 32'(hold_l));
    end
    if (out_valid && out_ready) begin
      beats++;
      t_last_beat = cyc;
      if (exp_q.size() != 0) begin
        check("beat_last", 32'(out_last), 32'(exp_q.size() == 1));
        check("beat_data", 32'(out_data), 32'(exp_q.pop_front()));
      end else check("extra_beat", 1, 0);
    end
    hold_v = out_valid && !out_ready;
    hold_d = out_data;
    hold_l = out_last;
    if (done && t_done < 0) begin
      t_done = cyc;
      busy_done = busy;
    end
  end

  task automatic expect_line(input int b, input int l);
    logic [W-1:0] word;
    exp_q.delete();
    exp_addr_q.delete();
    for (int k = 0; k < l; k++) exp_addr_q.push_back((b + k) % N);
    for (int j = 0; j < (l + W - 1) / W; j++) begin
      word = '0;
      for (int i = 0; i < W; i++) if (j * W + i < l) word[i] = ram[(b + j * W + i) % N];
      exp_q.push_back(word);
    end
    beats = 0; en_cnt = 0; t_valid = -1; t_done = -1; t_last_beat = -1; t_last_en = -1;
    hold_v = 1'b0; cyc = -1; busy1 = 1'b0; busy_done = 1'b1;
  endtask

  task automatic pulse_start(input int b, input int l);
    @(posedge clk);
    #1 base_addr = AW'(b); len = (AW + 1)'(l); start = 1'b1; mon = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic run(input int b, input int l, input bit rr, input bit extra_start);
    rand_rdy = rr;
    expect_line(b, l);
    pulse_start(b, l);
    if (extra_start) begin
      repeat (4) @(posedge clk);
      #1 base_addr = AW'(b + 100); len = 3; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
    end
    for (int i = 0; i < 20000 && t_done < 0; i++) @(posedge clk);
    repeat (3) @(posedge clk);
    mon = 1'b0;
    check("done_seen", 32'(t_done >= 0), 1);
    check("beats", 32'(beats), 32'((l + W - 1) / W));
    check("ram_en_count", 32'(en_cnt), 32'(l));
    check("words_left", 32'(exp_q.size()), 0);
    check("done_cycle", 32'(t_done), 32'(l == 0 ? 1 : t_last_beat + 1));
    check("busy_at_done", 32'(busy_done), 0);
    check("busy_early", 32'(busy1), 32'(l != 0));
    if (l == 0) check("no_valid", 32'(t_valid), 32'(-1));
    if (!rr && l != 0) begin
      check("first_valid", 32'(t_valid), 32'((l < W ? l : W) + 2));
      check("last_en_cycle", 32'(t_last_en), 32'(l));
    end
  endtask

  task automatic fill_ram(input int mode);
    for (int i = 0; i < N; i++) ram[i] = mode == 1 ? 1'b1 : 1'($urandom_range(0, 1));
  endtask

  initial begin
    repeat (3) @(posedge clk);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_ram_en", 32'(ram_en), 0);
    check("rst_ram_addr", 32'(ram_addr), 0);
    check("rst_valid", 32'(out_valid), 0);
    check("rst_data", 32'(out_data), 0);
    check("rst_last", 32'(out_last), 0);
    #1 rstn = 1'b1;
    fill_ram(2);
    {ram[0], ram[1], ram[2], ram[3], ram[4], ram[5], ram[6], ram[7]} = 8'b10110010;
    run(0, 8, 1'b0, 1'b0);
    fill_ram(1);
    run(0, 11, 1'b0, 1'b0);
    fill_ram(2);
    run(0, 2048, 1'b1, 1'b0);
    run(2045, 6, 1'b0, 1'b0);
    run(17, 0, 1'b0, 1'b0);
    run(300, 40, 1'b0, 1'b1);
    run(700, 40, 1'b1, 1'b1);
    for (int t = 0; t < 8; t++) begin
      fill_ram(2);
      run($urandom_range(0, N - 1), $urandom_range(1, 100), 1'($urandom_range(0, 1)), 1'b0);
    end
    rand_rdy = 1'b0;
    expect_line(0, 2048);
    pulse_start(0, 2048);
    for (int i = 0; i < 200 && beats < 3; i++) @(posedge clk);
    check("beats_before_reset", 32'(beats >= 3), 1);
    mon = 1'b0;
    #1 rstn = 1'b0;
    @(negedge clk);
    check("mid_busy", 32'(busy), 0);
    check("mid_done", 32'(done), 0);
    check("mid_ram_en", 32'(ram_en), 0);
    check("mid_ram_addr", 32'(ram_addr), 0);
    check("mid_valid", 32'(out_valid), 0);
    check("mid_data", 32'(out_data), 0);
    check("mid_last", 32'(out_last), 0);
    @(posedge clk);
    #1 rstn = 1'b1;
    fill_ram(2);
    run(0, 16, 1'b0, 1'b0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
